// File: rtl/async_fifo_lvl_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and read-mode codes.
package async_fifo_lvl_pkg;

    // Read-mode selector values for the FWFT parameter.
    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Binary to reflected Gray; callers zero-extend narrower pointers and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray to binary; leading zeros of a zero-extended input leave low bits exact.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_lvl_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module cdc_gray_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];

    // Each stage samples the previous one; the first samples the foreign pointer.
    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser chain, cleared by the local domain reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with Gray-pointer CDC, per-domain fill levels, programmable
// almost-full/almost-empty thresholds, over/underflow pulses and optional FWFT read.
module async_fifo_lvl
    import async_fifo_lvl_pkg::*;
#(
    parameter int DW          = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = DEPTH - 2,
    parameter int AEMPTY_TH   = 2,
    parameter int FWFT        = FWFT_OFF,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          wclk,
    input  logic          wrstn,
    input  logic          rclk,
    input  logic          rrstn,
    input  logic          wren,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   wr_level,
    output logic          overflow,
    input  logic          rden,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   rd_level,
    output logic          underflow
);

    localparam int          PW          = AW + 1;
    localparam logic [AW:0] PTR_ONE     = PW'(1);
    localparam logic [AW:0] AFULL_TH_L  = PW'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_TH_L = PW'(AEMPTY_TH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("async_fifo_lvl: DEPTH must be a power of 2 and at least 4");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
        $error("async_fifo_lvl: SYNC_STAGES must be in 2..4");
    end
    if ((AFULL_TH < 0) || (AFULL_TH > DEPTH) || (AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH)) begin : g_bad_th
        $error("async_fifo_lvl: thresholds must lie in 0..DEPTH");
    end

    logic [DW-1:0] mem [DEPTH];

    // Write domain state
    logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [AW:0] wr_level_q, wr_level_d;
    logic        full_q, full_d, afull_q, afull_d, overflow_q, overflow_d;
    logic [AW:0] rgray_s, rbin_s;
    logic        wr_acc_s;

    // Read domain state
    logic [AW:0]   rbin_q, rbin_d, rgray_q, rgray_d;
    logic [AW:0]   rd_level_q, rd_level_d;
    logic          empty_q, empty_d, aempty_q, aempty_d, underflow_q, underflow_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [AW:0]   wgray_s, wbin_s;
    logic          rd_acc_s;
    logic [AW-1:0] ridx_s;

    cdc_gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrstn),
        .d     (rgray_q),
        .q     (rgray_s)
    );

    cdc_gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrstn),
        .d     (wgray_q),
        .q     (wgray_s)
    );

    // Write-side next state: flags and level come from the post-write pointer.
    always_comb begin
        wr_acc_s = wren && !full_q;
        if (wr_acc_s) begin
            wbin_d = wbin_q + PTR_ONE;
        end else begin
            wbin_d = wbin_q;
        end
        wgray_d    = PW'(bin2gray(32'(wbin_d)));
        rbin_s     = PW'(gray2bin(32'(rgray_s)));
        full_d     = (wgray_d == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
        wr_level_d = wbin_d - rbin_s;
        afull_d    = (wr_level_d >= AFULL_TH_L);
        overflow_d = wren && full_q;
    end

    // Write-side registers.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            wr_level_q <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            wr_level_q <= wr_level_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array, written on accepted writes only; contents are never reset.
    always_ff @(posedge wclk) begin
        if (wr_acc_s) begin
            mem[wbin_q[AW-1:0]] <= wr_data;
        end
    end

    assign ridx_s = rbin_q[AW-1:0];

    // Read-side next state: flags and level come from the post-pop pointer.
    always_comb begin
        rd_acc_s = rden && !empty_q;
        if (rd_acc_s) begin
            rbin_d = rbin_q + PTR_ONE;
        end else begin
            rbin_d = rbin_q;
        end
        rgray_d     = PW'(bin2gray(32'(rbin_d)));
        wbin_s      = PW'(gray2bin(32'(wgray_s)));
        empty_d     = (rgray_d == wgray_s);
        rd_level_d  = wbin_s - rbin_d;
        aempty_d    = (rd_level_d <= AEMPTY_TH_L);
        underflow_d = rden && empty_q;
        if ((FWFT == FWFT_OFF) && rd_acc_s) begin
            rd_data_d = mem[ridx_s];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Read-side registers.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            rd_level_q  <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            rd_level_q  <= rd_level_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // In FWFT mode the head word is shown directly; when empty the held register (reset 0)
    // is shown instead so the output never carries stale or uninitialised memory.
    assign rd_data      = (FWFT == FWFT_ON) ? (empty_q ? rd_data_q : mem[ridx_s]) : rd_data_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign wr_level     = wr_level_q;
    assign overflow     = overflow_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign rd_level     = rd_level_q;
    assign underflow    = underflow_q;

endmodule
